// File: rtl/sha256_round_sequencer_if.sv
// Signal bundle between the dispatch/consumer side and one SHA-256 round sequencer.
// The master side offers blocks, hold and yumi; the slave side is the sequencer.
interface sha256_round_sequencer_if #(
   parameter int CTR_W = 6
);
   logic             v_i;
   logic             first_i;
   logic [511:0]     M_i;
   logic             ready_o;
   logic [511:0]     M_o;
   logic             init_o;
   logic [CTR_W-1:0] core_ctr_o;
   logic             round_v_o;
   logic             hold_i;
   logic             hash_load_o;
   logic             hash_update_o;
   logic             v_o;
   logic             yumi_i;
   logic             busy_o;

   modport master (
      output v_i, first_i, M_i, hold_i, yumi_i,
      input  ready_o, M_o, init_o, core_ctr_o, round_v_o,
             hash_load_o, hash_update_o, v_o, busy_o
   );

   modport slave (
      input  v_i, first_i, M_i, hold_i, yumi_i,
      output ready_o, M_o, init_o, core_ctr_o, round_v_o,
             hash_load_o, hash_update_o, v_o, busy_o
   );
endinterface

// File: rtl/sha256_round_sequencer.sv
// Control FSM for one SHA-256 core: registers a block, steps the scheduler and
// compression rounds, pulses the hash update and holds completion until taken.
module sha256_round_sequencer #(
   parameter int ROUNDS = 64,
   parameter int CTR_W  = 6
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   sha256_round_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      ROUND,
      UPDATE,
      DONE
   } state_t;

   localparam logic [CTR_W-1:0] LAST_CTR = CTR_W'(ROUNDS - 1);

   state_t           state_q, state_d;
   logic [CTR_W-1:0] ctr_q, ctr_d;
   logic [511:0]     m_q, m_d;
   logic             first_q, first_d;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         ctr_q   <= '0;
         m_q     <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         m_q     <= m_d;
         first_q <= first_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      ctr_d             = ctr_q;
      m_d               = m_q;
      first_d           = first_q;
      bus.ready_o       = 1'b0;
      bus.init_o        = 1'b0;
      bus.round_v_o     = 1'b0;
      bus.hash_load_o   = 1'b0;
      bus.hash_update_o = 1'b0;
      bus.v_o           = 1'b0;

      case (state_q)
         IDLE: begin
            bus.ready_o = 1'b1;
            if (bus.v_i) begin
               m_d     = bus.M_i;
               first_d = bus.first_i;
               state_d = INIT;
            end
         end
         INIT: begin
            // Round 0 consumes word 0 straight from M, so it runs alongside the load pulse.
            bus.init_o      = 1'b1;
            bus.round_v_o   = 1'b1;
            bus.hash_load_o = first_q;
            ctr_d           = CTR_W'(1);
            state_d         = ROUND;
         end
         ROUND: begin
            if (!bus.hold_i) begin
               bus.round_v_o = 1'b1;
               if (ctr_q == LAST_CTR) begin
                  ctr_d   = '0;
                  state_d = UPDATE;
               end else begin
                  ctr_d = ctr_q + CTR_W'(1);
               end
            end
         end
         UPDATE: begin
            bus.hash_update_o = 1'b1;
            ctr_d             = '0;
            state_d           = DONE;
         end
         DONE: begin
            bus.v_o = 1'b1;
            if (bus.yumi_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            ctr_d   = '0;
         end
      endcase
   end

   assign bus.M_o        = m_q;
   assign bus.core_ctr_o = ctr_q;
   assign bus.busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Self-checking bench for sha256_round_sequencer: directed cycle checks plus a
// scoreboard that validates each completed block when v_o rises.
module tb_sha256_round_sequencer;

   localparam int CTR_W = 6;

   typedef struct {
      logic [511:0] m;
      logic         first;
      int           done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset_i;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   planned_hold = 0;

   exp_t sb[$];

   sha256_round_sequencer_if #(.CTR_W(CTR_W)) bus ();

   sha256_round_sequencer #(.ROUNDS(64), .CTR_W(CTR_W)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboard monitor: records expectations on accept, validates on v_o rise.
   initial begin : monitor
      int   cnt_round;
      int   cnt_init;
      int   cnt_load;
      int   cnt_upd;
      logic v_prev;
      exp_t e;
      cnt_round = 0; cnt_init = 0; cnt_load = 0; cnt_upd = 0; v_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (reset_i) begin
            sb.delete();
            v_prev = 1'b0;
         end else begin
            if (bus.v_i && bus.ready_o) begin
               e.m        = bus.M_i;
               e.first    = bus.first_i;
               e.done_cyc = cyc + 66 + planned_hold;
               sb.push_back(e);
               cnt_round = 0; cnt_init = 0; cnt_load = 0; cnt_upd = 0;
            end
            if (bus.round_v_o)     cnt_round++;
            if (bus.init_o)        cnt_init++;
            if (bus.hash_load_o)   cnt_load++;
            if (bus.hash_update_o) cnt_upd++;
            if (bus.v_o && !v_prev) begin
               if (sb.size() == 0) begin
                  check("vo_unexpected", 1, 0);
               end else begin
                  e = sb.pop_front();
                  $display("block done at cycle %0d first=%0d rounds=%0d updates=%0d", cyc, e.first, cnt_round, cnt_upd);
                  check("sb_vo_cycle", cyc, e.done_cyc);
                  check("sb_M_o", bus.M_o, e.m);
                  check("sb_round_cnt", cnt_round, 64);
                  check("sb_init_cnt", cnt_init, 1);
                  check("sb_load_cnt", cnt_load, {511'b0, e.first});
                  check("sb_update_cnt", cnt_upd, 1);
               end
            end
            v_prev = bus.v_o;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset_i) begin
         assert (!(bus.hold_i && bus.busy_o && !bus.init_o && bus.core_ctr_o >= 6'd16))
            else $error("hold_i asserted during scheduler rounds 16..63");
      end
   end

   task automatic accept(input logic first, input logic [511:0] m, input int hold);
      @(posedge clk); #1;
      planned_hold = hold;
      bus.v_i     = 1'b1;
      bus.first_i = first;
      bus.M_i     = m;
      @(negedge clk);
      check("accept_ready", bus.ready_o, 1);
      @(posedge clk); #1;
      bus.v_i = 1'b0;
   endtask

   task automatic wait_vo();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.v_o && n < 200);
      if (!bus.v_o) check("vo_timeout", 0, 1);
   endtask

   task automatic consume(input int delay);
      for (int i = 0; i < delay; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("vo_held", bus.v_o, 1);
      end
      @(posedge clk); #1;
      bus.yumi_i = 1'b1;
      @(posedge clk); #1;
      bus.yumi_i = 1'b0;
   endtask

   logic [511:0] abc_blk;
   logic [511:0] blk2;
   logic [511:0] blk3;
   logic [511:0] junk;

   initial begin
      int n;
      int upd_seen;
      int vo_seen;
      abc_blk = {32'h61626380, 448'h0, 32'h00000018};
      blk2    = {16{32'hdeadbeef}};
      blk3    = {16{32'h0badcafe}};
      junk    = {16{32'h55aa33cc}};

      reset_i     = 1'b1;
      bus.v_i     = 1'b0;
      bus.first_i = 1'b0;
      bus.M_i     = '0;
      bus.hold_i  = 1'b0;
      bus.yumi_i  = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_i = 1'b0;
      @(negedge clk);
      check("rst_ready", bus.ready_o, 1);
      check("rst_M_o", bus.M_o, 0);
      check("rst_ctr", bus.core_ctr_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_v_o", bus.v_o, 0);
      check("rst_init", bus.init_o, 0);
      check("rst_round_v", bus.round_v_o, 0);
      check("rst_update", bus.hash_update_o, 0);

      // Single first block with no holds
      accept(1'b1, abc_blk, 0);
      @(negedge clk);
      check("init_pulse", bus.init_o, 1);
      check("init_hash_load", bus.hash_load_o, 1);
      check("init_ctr", bus.core_ctr_o, 0);
      check("init_round_v", bus.round_v_o, 1);
      for (int k = 1; k < 64; k++) begin
         @(negedge clk);
         check("round_ctr", bus.core_ctr_o, k);
         check("round_v", bus.round_v_o, 1);
      end
      @(negedge clk);
      check("update_pulse", bus.hash_update_o, 1);
      check("update_round_v", bus.round_v_o, 0);
      @(negedge clk);
      check("done_v_o", bus.v_o, 1);
      @(posedge clk); #1;
      bus.v_i = 1'b1;
      bus.M_i = junk;
      @(negedge clk);
      check("done_ready", bus.ready_o, 0);
      check("done_M_o_kept", bus.M_o, abc_blk);
      @(posedge clk); #1;
      bus.v_i = 1'b0;
      consume(0);
      @(negedge clk);
      check("idle_ready", bus.ready_o, 1);

      // Continuation block with back-pressure and spurious yumi during ROUND
      accept(1'b0, blk2, 0);
      repeat (3) @(posedge clk);
      #1;
      bus.yumi_i = 1'b1;
      bus.v_i    = 1'b1;
      bus.M_i    = junk;
      @(negedge clk);
      check("round_busy", bus.busy_o, 1);
      check("round_ready", bus.ready_o, 0);
      check("round_yumi_ignored", bus.core_ctr_o, 3);
      @(posedge clk); #1;
      bus.yumi_i = 1'b0;
      @(negedge clk);
      check("round_ctr_after_yumi", bus.core_ctr_o, 4);
      check("round_M_o_kept", bus.M_o, blk2);
      @(posedge clk); #1;
      bus.v_i = 1'b0;
      wait_vo();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("vo_held", bus.v_o, 1);
      end
      @(posedge clk); #1;
      bus.yumi_i   = 1'b1;
      bus.v_i      = 1'b1;
      bus.first_i  = 1'b1;
      bus.M_i      = blk3;
      planned_hold = 3;
      @(negedge clk);
      check("no_same_cycle_accept", bus.ready_o, 0);
      @(posedge clk); #1;
      bus.yumi_i = 1'b0;
      @(negedge clk);
      check("accept_after_yumi", bus.ready_o, 1);
      @(posedge clk); #1;
      bus.v_i = 1'b0;

      // Hold three cycles while the counter sits at 5
      repeat (5) @(posedge clk);
      #1 bus.hold_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_ctr", bus.core_ctr_o, 5);
         check("hold_round_v", bus.round_v_o, 0);
         @(posedge clk);
      end
      #1 bus.hold_i = 1'b0;
      @(negedge clk);
      check("hold_release_ctr", bus.core_ctr_o, 5);
      check("hold_release_round_v", bus.round_v_o, 1);
      wait_vo();
      consume(0);

      // Spurious yumi in IDLE
      @(posedge clk); #1;
      bus.yumi_i = 1'b1;
      @(negedge clk);
      check("idle_yumi_ready", bus.ready_o, 1);
      check("idle_yumi_busy", bus.busy_o, 0);
      @(posedge clk); #1;
      bus.yumi_i = 1'b0;
      @(negedge clk);
      check("idle_yumi_after", bus.busy_o, 0);

      // Reset in the middle of the rounds
      accept(1'b1, abc_blk, 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.core_ctr_o != 6'd40 && n < 100);
      check("reach_ctr40", bus.core_ctr_o, 40);
      reset_i = 1'b1;
      @(posedge clk); #1;
      reset_i = 1'b0;
      @(negedge clk);
      check("midrst_ready", bus.ready_o, 1);
      check("midrst_ctr", bus.core_ctr_o, 0);
      check("midrst_busy", bus.busy_o, 0);
      upd_seen = 0;
      vo_seen  = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (bus.hash_update_o) upd_seen++;
         if (bus.v_o) vo_seen++;
      end
      check("midrst_no_update", upd_seen, 0);
      check("midrst_no_vo", vo_seen, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sha256_round_sequencer.md
Name: sha256_round_sequencer

Overview:
- Controls one SHA-256 core. Accepts a 512-bit message block through a valid/ready handshake and registers it.
- Drives the message scheduler's load pulse and 6-bit round counter, and qualifies each compression round.
- Signals the final hash-state update, then holds a completion flag until the consumer takes it.
- Sits between the multicore dispatch logic and each core's message-scheduler/compression pair.

Parameters:
- ROUNDS, 64, number of compression rounds per block; the counter runs 0..ROUNDS-1.
- CTR_W, 6, width of the round counter; must satisfy 2^CTR_W >= ROUNDS.

Ports:
- clk_i  input  1  core clock; all state changes on its rising edge.
- reset_i  input  1  synchronous, active-high reset.
- v_i  input  1  a message block is offered on M_i.
- first_i  input  1  offered block is the first block of a message; sampled with v_i.
- M_i  input  512  message block; word 0 is in [511:480].
- ready_o  output  1  sequencer can accept a block this cycle.
- M_o  output  512  registered block, fed to the scheduler's message input.
- init_o  output  1  one-cycle load pulse to the scheduler init input.
- core_ctr_o  output  CTR_W  round index, fed to the scheduler counter input and the K-constant ROM.
- round_v_o  output  1  the compression function performs round core_ctr_o this cycle.
- hold_i  input  1  stall request from downstream; freezes the round progression.
- hash_load_o  output  1  load the initial H constants into the hash registers; pulses with init_o when first_i was set.
- hash_update_o  output  1  one-cycle pulse: add the working variables into H.
- v_o  output  1  block processing is complete and the hash registers are valid.
- yumi_i  input  1  consumer takes the result; only legal while v_o=1.
- busy_o  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on reset_i.
- Reset values:
  - state=IDLE.
  - ready_o=1. All other outputs 0, including M_o=0 and core_ctr_o=0.
  - The stored first flag is 0.
- Reset mid-operation: abandons the block; no hash_update_o pulse and no v_o follow it.
- States: IDLE, INIT, ROUND, UPDATE, DONE. All outputs are decoded from registered state, the counter and the stored first flag.
- IDLE:
  - ready_o=1.
  - On v_i&ready_o: latch M_i into M_o, latch first_i, go to INIT.
  - v_i=0: stay in IDLE; M_o keeps its value.
- INIT (one cycle):
  - init_o=1, core_ctr_o=0, round_v_o=1 (round 0 takes its word straight from M).
  - hash_load_o = stored first flag.
  - hold_i is ignored in INIT.
  - Next state is ROUND with counter=1.
- ROUND:
  - hold_i=0: round_v_o=1. If counter==ROUNDS-1, go to UPDATE; otherwise counter increments.
  - hold_i=1: round_v_o=0 and the counter freezes. The scheduler register keeps shifting on index>15, so downstream must not assert hold_i for rounds 16..63. Such a hold is a protocol violation and is flagged by a bench assertion.
- UPDATE (one cycle):
  - hash_update_o=1, round_v_o=0.
  - Counter returns to 0.
  - Next state is DONE.
- DONE:
  - v_o=1 and stays high until yumi_i.
  - On yumi_i, go to IDLE. ready_o first rises the cycle after yumi_i; there is no same-cycle accept.
- ready_o=0 in every state except IDLE. v_i there is ignored and M_o is not overwritten.
- Latency, with no holds and acceptance at cycle T:
  - INIT at T+1.
  - Rounds 1..63 at T+2..T+64.
  - UPDATE at T+65.
  - v_o first high at T+66.
- Throughput: one block per ROUNDS+3 cycles, plus however long the consumer takes to assert yumi_i.
- Counter arithmetic: unsigned, CTR_W bits, no wrap. The terminal value is ROUNDS-1 (6'b111111 at the default).
- yumi_i outside DONE is ignored.

Test Plan:
- Single block: reset, then v_i=1 and first_i=1 with M_i=the padded "abc" block.
  - Cycle after accept: init_o=1, hash_load_o=1, core_ctr_o=0.
  - Rounds: core_ctr_o steps 1..63 over 63 cycles.
  - Then hash_update_o=1 for one cycle; v_o=1 at T+66.
  - With the datapath attached, H0=0xba7816bf.
- Continuation block: accept a block with first_i=0.
  - hash_load_o stays 0 throughout.
  - Exactly one hash_update_o pulse and 64 cycles with round_v_o=1.
- Hold in early rounds: assert hold_i for 3 cycles while core_ctr_o=5.
  - core_ctr_o stays 5 and round_v_o=0 during the hold.
  - v_o arrives at T+69.
- Back-pressure:
  - Keep v_i=1 during ROUND: ready_o=0 and M_o is unchanged.
  - Delay yumi_i 10 cycles: v_o is held for those cycles. The next block is accepted exactly 1 cycle after yumi_i.
- Reset mid-operation: assert reset_i at core_ctr_o=40.
  - Next cycle: state IDLE, ready_o=1, core_ctr_o=0.
  - No hash_update_o pulse and no v_o follow.
- Spurious inputs:
  - yumi_i pulsed in IDLE and ROUND: no state change.
  - v_i in DONE: not accepted, M_o unchanged.
